// File: rtl/hdmi_audio_packetizer_pkg.sv
// Shared constants and types for the HDMI audio sample packetizer.
// Packet layout, IEC 60958 channel-status positions and slot format.
package hdmi_audio_packetizer_pkg;

  localparam logic [7:0] PKT_TYPE_AUDIO = 8'h02;
  localparam int unsigned BLOCK_LEN = 192;
  localparam logic [7:0] FRAME_LAST = 8'(BLOCK_LEN - 1);
  localparam int NUM_SLOTS = 4;

  localparam logic [7:0] CS_CAT_LSB = 8'd8;
  localparam logic [7:0] CS_CAT_MSB = 8'd15;
  localparam logic [7:0] CS_FS_LSB = 8'd24;
  localparam logic [7:0] CS_FS_MSB = 8'd27;
  localparam logic [7:0] CS_WL_LSB = 8'd32;
  localparam logic [7:0] CS_WL_MSB = 8'd35;

  typedef struct packed {
    logic [15:0] left;
    logic [15:0] right;
    logic [7:0]  frame;
  } slot_t;

  // SB6 = {PR,CR,UR,VR,PL,CL,UL,VL}; V and U are always zero.
  function automatic logic [55:0] subpacket(slot_t s, logic c);
    logic pl;
    logic pr;
    pl = ^s.left ^ c;
    pr = ^s.right ^ c;
    return {pr, c, 2'b00, pl, c, 2'b00,
            s.right, 8'h00, s.left, 8'h00};
  endfunction

endpackage

// File: rtl/hdmi_audio_packetizer_chstat.sv
// S/PDIF channel-status lookup: selects the C bit for one frame index.
// Category, sampling frequency and word length; every other bit is 0.
module hdmi_audio_packetizer_chstat
  import hdmi_audio_packetizer_pkg::*;
(
  input  logic [7:0] frame_i,
  input  logic [7:0] category_i,
  input  logic [3:0] sampling_freq_i,
  input  logic [3:0] word_length_i,
  output logic       c_bit_o
);

  logic [7:0] cat_off;
  logic [7:0] fs_off;
  logic [7:0] wl_off;

  assign cat_off = frame_i - CS_CAT_LSB;
  assign fs_off  = frame_i - CS_FS_LSB;
  assign wl_off  = frame_i - CS_WL_LSB;

  always_comb begin
    c_bit_o = 1'b0;
    unique case (1'b1)
      (frame_i >= CS_CAT_LSB && frame_i <= CS_CAT_MSB):
        c_bit_o = category_i[cat_off[2:0]];
      (frame_i >= CS_FS_LSB && frame_i <= CS_FS_MSB):
        c_bit_o = sampling_freq_i[fs_off[1:0]];
      (frame_i >= CS_WL_LSB && frame_i <= CS_WL_MSB):
        c_bit_o = word_length_i[wl_off[1:0]];
      default:
        c_bit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/hdmi_audio_packetizer.sv
// HDMI audio sample packetizer: buffers up to four stereo samples and
// emits one audio sample packet per scheduler request.
module hdmi_audio_packetizer
  import hdmi_audio_packetizer_pkg::*;
(
  input  logic         pixel_clock_i,
  input  logic         reset_i,
  input  logic         sample_fifo_empty_i,
  input  logic [31:0]  sample_fifo_read_data_i,
  output logic         sample_fifo_read_enable_o,
  input  logic [7:0]   spdif_category_code_i,
  input  logic [3:0]   spdif_sampling_freq_i,
  input  logic [3:0]   spdif_word_length_i,
  input  logic         packet_request_i,
  output logic         packet_valid_o,
  output logic [23:0]  packet_header_o,
  output logic [223:0] packet_body_o,
  output logic [2:0]   samples_pending_o
);

  slot_t [NUM_SLOTS-1:0] slot_q, slot_d;
  logic [2:0]   count_q, count_d;
  logic         inflight_q;
  logic [7:0]   frame_q, frame_d;
  logic         valid_q;
  logic [23:0]  header_q, header_d;
  logic [223:0] body_q, body_d;

  logic [NUM_SLOTS-1:0] c_bit;
  logic [3:0]   present;
  logic [3:0]   blk;
  logic [1:0]   wr_idx;
  logic         rd_en;
  logic         emit;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_cs
    hdmi_audio_packetizer_chstat u_cs (
      .frame_i         (slot_q[g].frame),
      .category_i      (spdif_category_code_i),
      .sampling_freq_i (spdif_sampling_freq_i),
      .word_length_i   (spdif_word_length_i),
      .c_bit_o         (c_bit[g])
    );
  end

  // A word already requested still needs a slot, so it counts as occupied.
  assign rd_en = !reset_i && !sample_fifo_empty_i
              && ((4'(count_q) + 4'(inflight_q)) < 4'd4);
  assign emit  = packet_request_i && (count_q != 3'd0);

  always_comb begin
    slot_d   = slot_q;
    count_d  = count_q;
    frame_d  = frame_q;
    header_d = header_q;
    body_d   = body_q;
    present  = '0;
    blk      = '0;
    wr_idx   = count_q[1:0];
    if (emit) begin
      body_d = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (3'(i) < count_q) begin
          present[i] = 1'b1;
          blk[i] = (slot_q[i].frame == 8'd0);
          body_d[56*i +: 56] = subpacket(slot_q[i], c_bit[i]);
        end
      end
      header_d = {blk, 4'b0000, 4'b0000, present, PKT_TYPE_AUDIO};
      count_d  = '0;
      wr_idx   = '0;
    end
    if (inflight_q) begin
      slot_d[wr_idx] = '{left:  sample_fifo_read_data_i[31:16],
                         right: sample_fifo_read_data_i[15:0],
                         frame: frame_q};
      count_d = count_d + 3'd1;
      frame_d = (frame_q == FRAME_LAST) ? 8'd0 : frame_q + 8'd1;
    end
  end

  always_ff @(posedge pixel_clock_i) begin
    if (reset_i) begin
      slot_q     <= '0;
      count_q    <= '0;
      inflight_q <= 1'b0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      header_q   <= '0;
      body_q     <= '0;
    end else begin
      slot_q     <= slot_d;
      count_q    <= count_d;
      inflight_q <= rd_en;
      frame_q    <= frame_d;
      valid_q    <= emit;
      header_q   <= header_d;
      body_q     <= body_d;
    end
  end

  assign sample_fifo_read_enable_o = rd_en;
  assign packet_valid_o    = valid_q;
  assign packet_header_o   = header_q;
  assign packet_body_o     = body_q;
  assign samples_pending_o = count_q;

endmodule

// File: tb/tb_hdmi_audio_packetizer.sv
// Bench for hdmi_audio_packetizer: FIFO model, queue-level reference model,
// packet scoreboard and directed corner cases plus a random stream.
module tb_hdmi_audio_packetizer;

  logic         clk = 1'b0;
  logic         reset;
  logic         empty;
  logic [31:0]  rd_data = '0;
  logic         rd_en;
  logic [7:0]   cat;
  logic [3:0]   fs;
  logic [3:0]   wl;
  logic         req;
  logic         valid;
  logic [23:0]  hdr;
  logic [223:0] body;
  logic [2:0]   pending;

  always #5 clk = ~clk;

  hdmi_audio_packetizer dut (
    .pixel_clock_i             (clk),
    .reset_i                   (reset),
    .sample_fifo_empty_i       (empty),
    .sample_fifo_read_data_i   (rd_data),
    .sample_fifo_read_enable_o (rd_en),
    .spdif_category_code_i     (cat),
    .spdif_sampling_freq_i     (fs),
    .spdif_word_length_i       (wl),
    .packet_request_i          (req),
    .packet_valid_o            (valid),
    .packet_header_o           (hdr),
    .packet_body_o             (body),
    .samples_pending_o         (pending)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    int          frame;
  } samp_t;

  typedef struct {
    logic [23:0]  hdr;
    logic [223:0] body;
  } pkt_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sample FIFO model
  logic [31:0] fifo_q[$];
  int push_cnt = 0;
  int pop_cnt = 0;
  assign empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (rd_en) begin
      if (fifo_q.size() > 0) rd_data <= fifo_q.pop_front();
      else rd_data <= 32'hDEAD_BEEF;
      pop_cnt <= pop_cnt + 1;
    end
  end

  task automatic push(logic [31:0] w);
    fifo_q.push_back(w);
    push_cnt++;
  endtask

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic bit cs_bit(int f);
    logic [191:0] cs;
    cs = '0;
    cs[15:8]  = cat;
    cs[27:24] = fs;
    cs[35:32] = wl;
    return cs[f];
  endfunction

  function automatic pkt_t build(samp_t b[$]);
    pkt_t p;
    logic [7:0] sb [7];
    bit c;
    p.hdr = 24'h000002;
    p.body = '0;
    foreach (b[n]) begin
      c = cs_bit(b[n].frame);
      p.hdr[8+n] = 1'b1;
      if (b[n].frame == 0) p.hdr[20+n] = 1'b1;
      sb[0] = 8'h00;
      sb[1] = b[n].l[7:0];
      sb[2] = b[n].l[15:8];
      sb[3] = 8'h00;
      sb[4] = b[n].r[7:0];
      sb[5] = b[n].r[15:8];
      sb[6] = '0;
      sb[6][2] = c;
      sb[6][3] = (($countones(b[n].l) + int'(c)) % 2) == 1;
      sb[6][6] = c;
      sb[6][7] = (($countones(b[n].r) + int'(c)) % 2) == 1;
      for (int k = 0; k < 7; k++) p.body[56*n + 8*k +: 8] = sb[k];
    end
    return p;
  endfunction

  // Reference model: queue of buffered samples, one pending FIFO read.
  samp_t mbuf[$];
  bit    m_infl = 0;
  int    m_frame = 0;
  bit    m_was_rst = 0;
  int    m_b_pkts = 0;
  pkt_t  sb_q[$];

  always @(posedge clk) begin
    bit cap;
    samp_t s;
    pkt_t p;
    m_was_rst = reset;
    if (reset) begin
      mbuf.delete();
      m_infl = 0;
      m_frame = 0;
    end else begin
      cap = m_infl;
      m_infl = (push_cnt != pop_cnt) && (mbuf.size() + int'(m_infl) < 4);
      if (req && mbuf.size() > 0) begin
        p = build(mbuf);
        if (p.hdr[23:20] != 4'h0) m_b_pkts++;
        sb_q.push_back(p);
        mbuf.delete();
      end
      if (cap) begin
        s.l = rd_data[31:16];
        s.r = rd_data[15:0];
        s.frame = m_frame;
        mbuf.push_back(s);
        m_frame = (m_frame + 1) % 192;
      end
    end
  end

  // Monitor
  pkt_t held = '{hdr: '0, body: '0};
  int   obs_b_pkts = 0;

  always @(negedge clk) begin
    bit exp_rd;
    if (m_was_rst) begin
      held.hdr = '0;
      held.body = '0;
    end
    exp_rd = !reset && (push_cnt != pop_cnt)
          && (mbuf.size() + int'(m_infl) < 4);
    check("valid", 256'(valid), 256'(sb_q.size() != 0));
    if (sb_q.size() != 0) held = sb_q.pop_front();
    if (valid && hdr[23:20] != 4'h0) obs_b_pkts++;
    check("header", 256'(hdr), 256'(held.hdr));
    check("body", 256'(body), 256'(held.body));
    check("pending", 256'(pending), 256'(mbuf.size()));
    check("rd_en", 256'(rd_en), 256'(exp_rd));
  end

  initial begin
    reset = 1'b1;
    req = 1'b0;
    cat = 8'h40;
    fs = 4'($urandom);
    wl = 4'($urandom);
    tick(3);
    check("rst_pending", 256'(pending), 256'(0));
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_header", 256'(hdr), 256'(0));
    reset = 1'b0;
    tick(1);

    // request before any capture
    req = 1'b1;
    tick(1);
    req = 1'b0;
    check("empty_req_valid", 256'(valid), 256'(0));
    tick(2);

    // four words, then a fifth that must wait
    push(32'h1234_ABCD);
    for (int i = 0; i < 3; i++) push($urandom);
    tick(8);
    push($urandom);
    @(negedge clk);
    check("full_pending", 256'(pending), 256'(4));
    check("full_rd_en", 256'(rd_en), 256'(0));
    @(posedge clk);
    #1 req = 1'b1;
    tick(1);
    req = 1'b0;
    check("full_valid", 256'(valid), 256'(1));
    check("full_hb0", 256'(hdr[7:0]), 256'(8'h02));
    check("full_hb1", 256'(hdr[15:8]), 256'(8'h0F));
    check("full_hb2", 256'(hdr[23:16]), 256'(8'h10));
    check("f0_sb0", 256'(body[7:0]), 256'(8'h00));
    check("f0_sb1", 256'(body[15:8]), 256'(8'h34));
    check("f0_sb2", 256'(body[23:16]), 256'(8'h12));
    check("f0_vl_ul_cl", 256'(body[50:48]), 256'(3'b000));
    check("f0_pl", 256'(body[51]), 256'(1));
    tick(1);
    check("pulse_one_cycle", 256'(valid), 256'(0));

    // flush, then a request on an empty buffer
    tick(3);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(3);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    check("empty_req2_valid", 256'(valid), 256'(0));
    tick(2);

    // request coinciding with a capture, two buffered
    push($urandom);
    push($urandom);
    tick(4);
    push($urandom);
    tick(1);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    check("coinc_hb1", 256'(hdr[15:8]), 256'(8'h03));
    check("coinc_pending", 256'(pending), 256'(1));
    tick(2);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(2);

    // reset with three buffered and one in flight
    push($urandom);
    push($urandom);
    push($urandom);
    tick(4);
    push($urandom);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_mid_pending", 256'(pending), 256'(0));
    push($urandom);
    tick(4);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    check("rst_mid_hb1", 256'(hdr[15:8]), 256'(8'h01));
    check("rst_mid_hb2", 256'(hdr[23:16]), 256'(8'h10));
    tick(2);

    // random stream, well past one 192-frame block
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 1) == 0) push($urandom);
      req = ($urandom_range(0, 5) == 0);
      tick(1);
    end
    req = 1'b0;
    tick(20);
    req = 1'b1;
    tick(1);
    req = 1'b0;
    tick(4);

    check("sb_drained", 256'(sb_q.size()), 256'(0));
    check("b_packets", 256'(obs_b_pkts), 256'(m_b_pkts));
    check("b_packets_min", 256'(obs_b_pkts >= 3), 256'(1));
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
